rv_mul_unit: RTL

Parametrised, pipelined integer multiplier for the RV32M execute stage. It covers all four RISC-V multiply ops (MUL, MULH, MULHSU, MULHU) with per-operand signedness. Latency is set by a depth parameter, and the block keeps the start/done handshake the EX-stage controller already drives. It replaces the unsigned-only fixed-latency multiplier and sits beside the divider in the M-extension path.

---
 rtl/rv_mul_pkg.sv | 23 ++
 rtl/rv_mul_unit_core.sv | 101 ++++++++++
 rtl/rv_mul_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/rv_mul_pkg.sv
// Shared types and helpers for the RV32M multiply unit.
// Op encoding matches funct3[1:0] so the decoder can forward it untouched.
package rv_mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    // Cycles from the accepting edge to the cycle in which done is high.
    function automatic int mul_latency(input int pipe_stages);
        return pipe_stages + 1;
    endfunction

endpackage

// File: rtl/rv_mul_unit_core.sv
// Signed (WIDTH+1)x(WIDTH+1) multiplier keeping the low 2*WIDTH product bits.
// Rows are folded by a carry-save chain split evenly over PIPE_STAGES registers.
module mul_array_core #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH:0]       a,
    input  logic [WIDTH:0]       b,
    input  logic                 valid_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 valid_out
);

    localparam int N    = WIDTH + 1;
    localparam int P    = 2 * WIDTH;
    localparam int ROWS = N + 1;

    // Row N-1 carries the negative weight of b's sign bit as ~(a<<W); the
    // extra row supplies the +1 that completes that two's-complement negation.
    function automatic logic [P-1:0] pp_row(input logic [N-1:0] x,
                                            input logic [N-1:0] y,
                                            input int i);
        logic [P-1:0] xs;
        xs = {{(P-N){x[N-1]}}, x};
        if (i < N - 1)       return y[i]   ? (xs << i)        : '0;
        else if (i == N - 1) return y[N-1] ? ~(xs << (N - 1)) : '0;
        else                 return y[N-1] ? P'(1)            : '0;
    endfunction

    logic [P-1:0] s_w [PIPE_STAGES];
    logic [P-1:0] c_w [PIPE_STAGES];
    logic [N-1:0] a_w [PIPE_STAGES];
    logic [N-1:0] b_w [PIPE_STAGES];
    logic         v_w [PIPE_STAGES+1];

    assign s_w[0] = '0;
    assign c_w[0] = '0;
    assign a_w[0] = a;
    assign b_w[0] = b;
    assign v_w[0] = valid_in;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        localparam int LO = (k * ROWS) / PIPE_STAGES;
        localparam int HI = ((k + 1) * ROWS) / PIPE_STAGES;

        logic [P-1:0] s_nx, c_nx;
        logic         v_q;

        always_comb begin
            logic [P-1:0] row, t;
            row  = '0;
            t    = '0;
            s_nx = s_w[k];
            c_nx = c_w[k];
            for (int i = LO; i < HI; i++) begin
                row  = pp_row(a_w[k], b_w[k], i);
                t    = s_nx ^ c_nx ^ row;
                c_nx = ((s_nx & c_nx) | (s_nx & row) | (c_nx & row)) << 1;
                s_nx = t;
            end
        end

        assign v_w[k+1] = v_q;

        if (k < PIPE_STAGES - 1) begin : g_mid
            logic [P-1:0] s_q, c_q;
            logic [N-1:0] a_q, b_q;

            always_ff @(posedge clk) begin
                if (rst) v_q <= 1'b0;
                else     v_q <= v_w[k];
                if (v_w[k]) begin
                    s_q <= s_nx;
                    c_q <= c_nx;
                    a_q <= a_w[k];
                    b_q <= b_w[k];
                end
            end

            assign s_w[k+1] = s_q;
            assign c_w[k+1] = c_q;
            assign a_w[k+1] = a_q;
            assign b_w[k+1] = b_q;
        end else begin : g_last
            logic [P-1:0] prod_q;

            always_ff @(posedge clk) begin
                if (rst) v_q <= 1'b0;
                else     v_q <= v_w[k];
                if (v_w[k]) prod_q <= s_nx + c_nx;
            end

            assign product = prod_q;
        end
    end

    assign valid_out = v_w[PIPE_STAGES];

endmodule

// File: rtl/rv_mul_unit.sv
// RV32M multiply unit: start/done FSM, operand sign extension and half select.
// Handshake: start is taken only in IDLE; done pulses one cycle with result valid.
module rv_mul_unit
    import rv_mul_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  mul_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output mul_state_t       fsm_state
);

    localparam int LATENCY = mul_latency(PIPE_STAGES);
    localparam int CNT_W   = (PIPE_STAGES > 1) ? $clog2(PIPE_STAGES) : 1;

    mul_state_t         state, state_nx;
    logic [CNT_W-1:0]   cnt;
    mul_op_t            op_q;
    logic               accept;
    logic [WIDTH:0]     a_ext, b_ext;
    logic [2*WIDTH-1:0] product;
    logic               core_valid;

    assign accept = (state == IDLE) && start;

    // MUL's low half is sign-agnostic, so it shares MULH's extension.
    assign a_ext = {(op != MULHU) & a[WIDTH-1], a};
    assign b_ext = {((op == MUL) || (op == MULH)) & b[WIDTH-1], b};

    mul_array_core #(
        .WIDTH       (WIDTH),
        .PIPE_STAGES (PIPE_STAGES)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .a         (a_ext),
        .b         (b_ext),
        .valid_in  (accept),
        .product   (product),
        .valid_out (core_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= MUL;
            result <= '0;
        end else begin
            state <= state_nx;
            if (state == CALC) cnt <= cnt + 1'b1;
            else               cnt <= '0;
            if (accept) op_q <= op;
            if (core_valid && (state == CALC))
                result <= (op_q == MUL) ? product[WIDTH-1:0]
                                        : product[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == CNT_W'(LATENCY - 2)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign done      = (state == DONE);
    assign busy      = (state == CALC);
    assign fsm_state = state;

endmodule
